// File: rtl/micro_pkg.sv
// Shared definitions for the 8-bit microprocessor datapath: default bus widths
// and the store-unit state encoding.
package micro_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/bus_store_unit_if.sv
// External write bus of the store unit: address/data, write strobe and the
// slave's acknowledge (four-phase handshake).
interface bus_store_unit_if #(
  parameter int DATA_W = micro_pkg::DATA_W,
  parameter int ADDR_W = micro_pkg::ADDR_W
);

  logic [DATA_W-1:0] Dataout_Bus;
  logic [ADDR_W-1:0] Adress_Data_Bus;
  logic              bus_we;
  logic              bus_ack;

  modport master (
    output Dataout_Bus,
    output Adress_Data_Bus,
    output bus_we,
    input  bus_ack
  );

  modport slave (
    input  Dataout_Bus,
    input  Adress_Data_Bus,
    input  bus_we,
    output bus_ack
  );

endinterface

// File: rtl/bus_store_unit_store_timer.sv
// Clearable saturating up-counter with a ">= limit" terminal flag; used for the
// setup delay and for the optional ack timeout.
module store_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         term
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign term = (cnt_q >= limit);

endmodule

// File: rtl/bus_store_unit.sv
// Store bus master: latches a store request and runs a four-phase bus_we/bus_ack
// handshake. Define STORE_TIMEOUT_EN to abort transfers whose ack never arrives.
module bus_store_unit #(
  parameter int DATA_W    = micro_pkg::DATA_W,
  parameter int ADDR_W    = micro_pkg::ADDR_W,
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  bus_store_unit_if.master  bus
);

  import micro_pkg::*;

  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("SETUP_CYC must be within 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must be within 1..255");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q, busy_q, done_q, err_q;
  logic              we_d, busy_d, done_d, err_d;
  logic              start, setup_term, timeout;

  assign start = (state_q == ST_IDLE) && st_req;

  store_timer #(.W(4)) u_setup_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (state_q == ST_SETUP),
    .limit (4'(SETUP_CYC - 1)),
    .term  (setup_term)
  );

`ifdef STORE_TIMEOUT_EN
  logic wait_term;

  // Restarts on entry to each wait state, so STROBE and RELEASE each get TIMEOUT cycles.
  store_timer #(.W(8)) u_timeout_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (((state_q == ST_SETUP) && setup_term) || ((state_q == ST_STROBE) && bus.bus_ack)),
    .inc   ((state_q == ST_STROBE) || (state_q == ST_RELEASE)),
    .limit (8'(TIMEOUT - 1)),
    .term  (wait_term)
  );

  assign timeout = wait_term &&
                   (((state_q == ST_STROBE) && !bus.bus_ack) ||
                    ((state_q == ST_RELEASE) && bus.bus_ack));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q <= st_addr;
        data_q <= st_data;
      end
      we_q   <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (st_req) state_d = ST_SETUP;
      ST_SETUP:   if (setup_term) state_d = ST_STROBE;
      ST_STROBE:  if (bus.bus_ack) state_d = ST_RELEASE;
                  else if (timeout) state_d = ST_IDLE;
      ST_RELEASE: if (!bus.bus_ack || timeout) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the strobe never glitches.
  always_comb begin
    we_d   = (state_d == ST_STROBE);
    busy_d = (state_d != ST_IDLE);
    done_d = ((state_q == ST_RELEASE) && !bus.bus_ack) || timeout;
    err_d  = timeout;
  end

  assign st_busy             = busy_q;
  assign st_done             = done_q;
  assign st_err              = err_q;
  assign bus.bus_we          = we_q;
  assign bus.Adress_Data_Bus = addr_q;
  assign bus.Dataout_Bus     = data_q;

endmodule

// File: tb/tb_bus_store_unit.sv
// Scoreboard bench for bus_store_unit: instance 0 uses SETUP_CYC=1, instance 1
// SETUP_CYC=3; each has its own negedge slave model and completion monitor.
`timescale 1ns/1ps
module tb_bus_store_unit;

  localparam int N     = 2;
  localparam int NEVER = 1000;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
    int         setup_c;
    int         we_c;
    int         busy_c;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       st_req  [N];
  logic [7:0] st_addr [N];
  logic [7:0] st_data [N];
  wire [N-1:0] st_busy, st_done, st_err, we_mon;
  wire [7:0]  addr_mon [N];
  wire [7:0]  data_mon [N];
  int         ack_dly [N];   // 0: ack follows bus_we combinationally
  exp_t       exp_q [N][$];
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_u
    bus_store_unit_if #(.DATA_W(8), .ADDR_W(8)) bif ();
    logic ack_drv = 1'b0;

    bus_store_unit #(
      .DATA_W(8), .ADDR_W(8), .SETUP_CYC(g == 0 ? 1 : 3), .TIMEOUT(15)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .st_req  (st_req[g]),
      .st_addr (st_addr[g]),
      .st_data (st_data[g]),
      .st_busy (st_busy[g]),
      .st_done (st_done[g]),
      .st_err  (st_err[g]),
      .bus     (bif)
    );

    assign bif.bus_ack = (ack_dly[g] == 0) ? bif.bus_we : ack_drv;
    assign we_mon[g]   = bif.bus_we;
    assign addr_mon[g] = bif.Adress_Data_Bus;
    assign data_mon[g] = bif.Dataout_Bus;

    // Slave: ack after ack_dly strobe cycles, release one cycle after bus_we drops.
    initial begin
      int hi = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          ack_drv = 1'b0;
          hi = 0;
        end else if (bif.bus_we) begin
          hi++;
          if (ack_dly[g] != NEVER && hi >= ack_dly[g]) ack_drv = 1'b1;
        end else begin
          hi = 0;
          ack_drv = 1'b0;
        end
      end
    end

    // Monitor: measures each transfer and compares it with the queued expectation on st_done.
    initial begin
      int busy_c = 0, setup_c = 0, we_c = 0;
      logic seen_we = 1'b0, moved = 1'b0;
      logic [7:0] a0 = '0, d0 = '0;
      exp_t e;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          busy_c = 0; setup_c = 0; we_c = 0; seen_we = 1'b0; moved = 1'b0;
        end else begin
          if (st_busy[g]) begin
            if (busy_c == 0) begin
              a0 = bif.Adress_Data_Bus;
              d0 = bif.Dataout_Bus;
            end else if (bif.Adress_Data_Bus !== a0 || bif.Dataout_Bus !== d0) begin
              moved = 1'b1;
            end
            busy_c++;
            if (bif.bus_we) begin
              seen_we = 1'b1;
              we_c++;
            end else if (!seen_we) begin
              setup_c++;
            end
          end
          if (st_done[g]) begin
            if (exp_q[g].size() == 0) begin
              check($sformatf("u%0d done with empty queue", g), exp_q[g].size(), 1);
            end else begin
              e = exp_q[g].pop_front();
              check($sformatf("u%0d addr", g), a0, e.addr);
              check($sformatf("u%0d data", g), d0, e.data);
              check($sformatf("u%0d st_err", g), st_err[g], e.err);
              check($sformatf("u%0d setup cycles", g), setup_c, e.setup_c);
              check($sformatf("u%0d we cycles", g), we_c, e.we_c);
              check($sformatf("u%0d busy cycles", g), busy_c, e.busy_c);
              check($sformatf("u%0d busy at done", g), st_busy[g], 0);
              check($sformatf("u%0d buses stable", g), moved, 0);
            end
            busy_c = 0; setup_c = 0; we_c = 0; seen_we = 1'b0; moved = 1'b0;
          end else if (st_err[g]) begin
            check($sformatf("u%0d st_err without st_done", g), st_err[g], 0);
          end
        end
      end
    end
  end

  task automatic push(input int g, input logic [7:0] a, input logic [7:0] d, input logic err,
                      input int s, input int w, input int b);
    exp_t e;
    e.addr = a; e.data = d; e.err = err; e.setup_c = s; e.we_c = w; e.busy_c = b;
    exp_q[g].push_back(e);
  endtask

  task automatic issue(input int g, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    st_req[g] = 1'b1; st_addr[g] = a; st_data[g] = d;
    @(posedge clk); #1;
    st_req[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!st_done[g] && n < budget);
    check({name, " done reached"}, st_done[g], 1);
  endtask

  task automatic wait_we(input int g, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!we_mon[g] && n < budget);
    check({name, " bus_we reached"}, we_mon[g], 1);
  endtask

  task automatic check_idle_zero(input int g, input string name);
    check({name, " bus_we"}, we_mon[g], 0);
    check({name, " st_busy"}, st_busy[g], 0);
    check({name, " st_done"}, st_done[g], 0);
    check({name, " st_err"}, st_err[g], 0);
    check({name, " addr"}, addr_mon[g], 0);
    check({name, " data"}, data_mon[g], 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      st_req[i] = 1'b0; st_addr[i] = '0; st_data[i] = '0; ack_dly[i] = 1;
    end
    #2 rst_n = 1'b0;
    #1 check_idle_zero(0, "reset u0");
    check_idle_zero(1, "reset u1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic store, one-cycle ack.
    push(0, 8'h3C, 8'hA5, 1'b0, 1, 1, 3);
    issue(0, 8'h3C, 8'hA5);
    wait_done(0, 20, "basic");

    // Wait states on the SETUP_CYC=3 instance.
    ack_dly[1] = 5;
    push(1, 8'h5A, 8'hC3, 1'b0, 3, 5, 9);
    issue(1, 8'h5A, 8'hC3);
    wait_done(1, 30, "wait states");

    // Request while busy is dropped.
    ack_dly[0] = 3;
    push(0, 8'h3C, 8'hA5, 1'b0, 1, 3, 5);
    issue(0, 8'h3C, 8'hA5);
    wait_we(0, 10, "busy req");
    @(posedge clk); #1;
    st_req[0] = 1'b1; st_addr[0] = 8'h10; st_data[0] = 8'h77;
    @(posedge clk); #1;
    st_req[0] = 1'b0;
    wait_done(0, 20, "busy req");
    repeat (5) @(negedge clk);
    check("busy req idle addr held", addr_mon[0], 8'h3C);
    check("busy req idle data held", data_mon[0], 8'hA5);

    // Held request with a zero-wait slave: back-to-back transfers.
    ack_dly[0] = 0;
    push(0, 8'h01, 8'h11, 1'b0, 1, 1, 3);
    push(0, 8'h02, 8'h22, 1'b0, 1, 1, 3);
    @(posedge clk); #1;
    st_req[0] = 1'b1; st_addr[0] = 8'h01; st_data[0] = 8'h11;
    @(posedge clk); #1;
    st_addr[0] = 8'h02; st_data[0] = 8'h22;
    wait_done(0, 20, "held first");
    check("held busy low at done", st_busy[0], 0);
    @(posedge clk); #1;
    check("held restart busy", st_busy[0], 1);
    check("held restart addr", addr_mon[0], 8'h02);
    st_req[0] = 1'b0;
    wait_done(0, 20, "held second");

    // Asynchronous reset mid-STROBE aborts without st_done.
    ack_dly[1] = 5;
    issue(1, 8'h99, 8'h66);
    wait_we(1, 20, "async reset");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 check_idle_zero(1, "async reset u1");
    check("async reset u0 addr", addr_mon[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(1, 8'h44, 8'hBB, 1'b0, 3, 5, 9);
    issue(1, 8'h44, 8'hBB);
    wait_done(1, 30, "after reset");

    // Slave never acknowledges.
    ack_dly[0] = NEVER;
`ifdef STORE_TIMEOUT_EN
    push(0, 8'hE7, 8'h7E, 1'b1, 1, 15, 16);
    issue(0, 8'hE7, 8'h7E);
    wait_done(0, 40, "timeout");
    @(negedge clk);
    check("timeout idle we", we_mon[0], 0);
    check("timeout idle busy", st_busy[0], 0);
    check("timeout done one cycle", st_done[0], 0);
`else
    issue(0, 8'hE7, 8'h7E);
    repeat (40) @(negedge clk);
    check("no ack we held", we_mon[0], 1);
    check("no ack busy held", st_busy[0], 1);
    check("no ack err", st_err[0], 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check("no ack reset we", we_mon[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (5) @(negedge clk);
    check("u0 queue drained", exp_q[0].size(), 0);
    check("u1 queue drained", exp_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
